// File: rtl/pushbutton_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : pushbutton_conditioner_if
// Purpose  : Signal bundle between the raw pushbutton source / processor side
//            and the pushbutton conditioner.
// Signals  : btn_raw     - raw asynchronous buttons, 1 = pressed
//            clr         - clear strobe for sticky flags and overruns
//            btn_level   - debounced level (feeds uP.pushbuttons)
//            btn_pulse   - one-cycle pulse on each debounced 0->1 edge
//            btn_flag    - sticky press indicator per bit
//            btn_overrun - sticky: a press arrived while its flag was set
//            any_flag    - OR of btn_flag
// Modports : master - drives btn_raw/clr, observes the conditioned outputs
//            slave  - the conditioner itself
// Revision : 1.0 - initial release
// ============================================================================
interface pushbutton_conditioner_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] btn_raw;
    logic             clr;
    logic [WIDTH-1:0] btn_level;
    logic [WIDTH-1:0] btn_pulse;
    logic [WIDTH-1:0] btn_flag;
    logic [WIDTH-1:0] btn_overrun;
    logic             any_flag;

    modport master (
        output btn_raw,
        output clr,
        input  btn_level,
        input  btn_pulse,
        input  btn_flag,
        input  btn_overrun,
        input  any_flag
    );

    modport slave (
        input  btn_raw,
        input  clr,
        output btn_level,
        output btn_pulse,
        output btn_flag,
        output btn_overrun,
        output any_flag
    );
endinterface
`default_nettype wire

// File: rtl/pushbutton_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : pushbutton_conditioner
// Purpose  : Per-bit 2-flop synchronizer plus consecutive-cycle debounce
//            filter for the pushbutton inputs, producing clean levels,
//            one-cycle press pulses and sticky press/overrun flags that the
//            processor clears with a strobe when it reads its input port.
// Ports    : clock - system clock, rising edge
//            reset - synchronous, active-high
//            bus   - pushbutton_conditioner_if.slave (see interface header)
// Revision : 1.0 - initial release
// ============================================================================
module pushbutton_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  wire logic                     clock,
    input  wire logic                     reset,
    pushbutton_conditioner_if.slave       bus
);
    localparam int             C_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam [C_CNT_W-1:0]   C_LAST  = C_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_level;
    logic [WIDTH-1:0]   r_pulse;
    logic [WIDTH-1:0]   r_flag;
    logic [WIDTH-1:0]   r_overrun;
    logic [C_CNT_W-1:0] r_cnt [WIDTH];

    // w_update: the mismatch has persisted long enough, level takes sync2 now.
    // w_rise  : that update is a 0->1 transition.
    logic [WIDTH-1:0]   w_update;
    logic [WIDTH-1:0]   w_rise;

    always_comb begin
        w_update = '0;
        w_rise   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_update[i] = (r_sync2[i] != r_level[i]) && (r_cnt[i] == C_LAST);
            w_rise[i]   = w_update[i] && r_sync2[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level   <= '0;
            r_pulse   <= '0;
            r_flag    <= '0;
            r_overrun <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= bus.btn_raw;
            r_sync2 <= r_sync1;
            r_pulse <= w_rise;

            for (int i = 0; i < WIDTH; i++) begin
                // Any return to the current level restarts the count, so only
                // an uninterrupted run of DEBOUNCE_CYCLES mismatches commits.
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_update[i]) begin
                    r_level[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end

                // A rise always sets the flag, even when clr arrives on the
                // same edge, so a press coinciding with a read is not lost.
                if (w_rise[i]) begin
                    r_flag[i] <= 1'b1;
                    if (bus.clr) begin
                        r_overrun[i] <= 1'b0;
                    end else if (r_flag[i]) begin
                        r_overrun[i] <= 1'b1;
                    end
                end else if (bus.clr) begin
                    r_flag[i]    <= 1'b0;
                    r_overrun[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.btn_level   = r_level;
    assign bus.btn_pulse   = r_pulse;
    assign bus.btn_flag    = r_flag;
    assign bus.btn_overrun = r_overrun;
    assign bus.any_flag    = |r_flag;

endmodule
`default_nettype wire

// File: tb/tb_pushbutton_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_pushbutton_conditioner
// Purpose  : Directed self-checking bench for pushbutton_conditioner.
//            Inputs change and outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pushbutton_conditioner;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    pushbutton_conditioner_if #(.WIDTH(4)) bus ();

    pushbutton_conditioner #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance n rising edges, landing on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.btn_raw = 4'b0000;
        bus.clr     = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.clr     = 1'b0;
        bus.btn_raw = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            step(1);
            checks++;
            if ({bus.btn_level, bus.btn_pulse, bus.btn_flag, bus.btn_overrun, bus.any_flag} !== 17'd0) begin
                failures++;
                $display("FAIL reset_during lvl=%b pls=%b flg=%b ovr=%b any=%b exp all 0",
                         bus.btn_level, bus.btn_pulse, bus.btn_flag, bus.btn_overrun, bus.any_flag);
            end
        end
        reset = 1'b0;
        step(5);
        checks++;
        if (bus.btn_level !== 4'b0000 || bus.btn_pulse !== 4'b0000) begin
            failures++;
            $display("FAIL reset_after_edge4 lvl=%b pls=%b exp 0000/0000", bus.btn_level, bus.btn_pulse);
        end
        step(1);
        checks++;
        if (bus.btn_level !== 4'b1111 || bus.btn_pulse !== 4'b1111) begin
            failures++;
            $display("FAIL reset_after_edge5 lvl=%b pls=%b exp 1111/1111", bus.btn_level, bus.btn_pulse);
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        bus.btn_raw = 4'b0010;
        step(5);
        checks++;
        if (bus.btn_level !== 4'b0000 || bus.btn_pulse !== 4'b0000 || bus.any_flag !== 1'b0) begin
            failures++;
            $display("FAIL press_edge4 lvl=%b pls=%b any=%b exp 0000/0000/0",
                     bus.btn_level, bus.btn_pulse, bus.any_flag);
        end
        step(1);
        checks++;
        if (bus.btn_level !== 4'b0010 || bus.btn_pulse !== 4'b0010 ||
            bus.btn_flag !== 4'b0010 || bus.any_flag !== 1'b1) begin
            failures++;
            $display("FAIL press_edge5 lvl=%b pls=%b flg=%b any=%b exp 0010/0010/0010/1",
                     bus.btn_level, bus.btn_pulse, bus.btn_flag, bus.any_flag);
        end
        step(1);
        checks++;
        if (bus.btn_level !== 4'b0010 || bus.btn_pulse !== 4'b0000 ||
            bus.btn_flag !== 4'b0010 || bus.btn_overrun !== 4'b0000) begin
            failures++;
            $display("FAIL press_edge6 lvl=%b pls=%b flg=%b ovr=%b exp 0010/0000/0010/0000",
                     bus.btn_level, bus.btn_pulse, bus.btn_flag, bus.btn_overrun);
        end
    endtask

    // Continues from test_clean_press with btn_flag = 0010.
    task automatic test_clear();
        bus.clr = 1'b1;
        step(1);
        bus.clr = 1'b0;
        checks++;
        if (bus.btn_flag !== 4'b0000 || bus.any_flag !== 1'b0 || bus.btn_level !== 4'b0010) begin
            failures++;
            $display("FAIL clear flg=%b any=%b lvl=%b exp 0000/0/0010",
                     bus.btn_flag, bus.any_flag, bus.btn_level);
        end
        // Release produces no pulse and no flag.
        bus.btn_raw = 4'b0000;
        step(5);
        checks++;
        if (bus.btn_level !== 4'b0010) begin
            failures++;
            $display("FAIL release_edge4 lvl=%b exp 0010", bus.btn_level);
        end
        step(1);
        checks++;
        if (bus.btn_level !== 4'b0000 || bus.btn_pulse !== 4'b0000 || bus.btn_flag !== 4'b0000) begin
            failures++;
            $display("FAIL release_edge5 lvl=%b pls=%b flg=%b exp 0000/0000/0000",
                     bus.btn_level, bus.btn_pulse, bus.btn_flag);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] pattern;
        do_reset();
        pattern = 4'b1010;
        for (int p = 3; p >= 0; p--) begin
            bus.btn_raw = {3'b000, pattern[p]};
            for (int s = 0; s < 2; s++) begin
                step(1);
                checks++;
                if (bus.btn_level !== 4'b0000 || bus.btn_pulse !== 4'b0000) begin
                    failures++;
                    $display("FAIL bounce_toggle p=%0d s=%0d lvl=%b pls=%b exp 0000/0000",
                             p, s, bus.btn_level, bus.btn_pulse);
                end
            end
        end
        bus.btn_raw = 4'b0001;
        for (int s = 0; s < 5; s++) begin
            step(1);
            checks++;
            if (bus.btn_level !== 4'b0000 || bus.btn_pulse !== 4'b0000) begin
                failures++;
                $display("FAIL bounce_hold edge=%0d lvl=%b pls=%b exp 0000/0000",
                         s, bus.btn_level, bus.btn_pulse);
            end
        end
        step(1);
        checks++;
        if (bus.btn_level !== 4'b0001 || bus.btn_pulse !== 4'b0001) begin
            failures++;
            $display("FAIL bounce_settle lvl=%b pls=%b exp 0001/0001", bus.btn_level, bus.btn_pulse);
        end
    endtask

    task automatic test_collision();
        do_reset();
        bus.btn_raw = 4'b1000;
        step(5);
        bus.clr = 1'b1;         // sampled on edge 5, same edge as the rise
        step(1);
        bus.clr = 1'b0;
        checks++;
        if (bus.btn_flag !== 4'b1000 || bus.btn_overrun !== 4'b0000 || bus.btn_pulse !== 4'b1000) begin
            failures++;
            $display("FAIL collision flg=%b ovr=%b pls=%b exp 1000/0000/1000",
                     bus.btn_flag, bus.btn_overrun, bus.btn_pulse);
        end
        bus.btn_raw = 4'b0000;
        step(6);
        bus.btn_raw = 4'b1000;
        step(5);
        checks++;
        if (bus.btn_overrun !== 4'b0000) begin
            failures++;
            $display("FAIL overrun_early ovr=%b exp 0000", bus.btn_overrun);
        end
        step(1);
        checks++;
        if (bus.btn_overrun !== 4'b1000 || bus.btn_flag !== 4'b1000 || bus.btn_pulse !== 4'b1000) begin
            failures++;
            $display("FAIL overrun_set ovr=%b flg=%b pls=%b exp 1000/1000/1000",
                     bus.btn_overrun, bus.btn_flag, bus.btn_pulse);
        end
        bus.btn_raw = 4'b0000;
        step(6);
        checks++;
        if (bus.btn_overrun !== 4'b1000 || bus.btn_flag !== 4'b1000 || bus.btn_level !== 4'b0000) begin
            failures++;
            $display("FAIL overrun_hold ovr=%b flg=%b lvl=%b exp 1000/1000/0000",
                     bus.btn_overrun, bus.btn_flag, bus.btn_level);
        end
        bus.clr = 1'b1;
        step(1);
        bus.clr = 1'b0;
        checks++;
        if (bus.btn_overrun !== 4'b0000 || bus.btn_flag !== 4'b0000 || bus.any_flag !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear ovr=%b flg=%b any=%b exp 0000/0000/0",
                     bus.btn_overrun, bus.btn_flag, bus.any_flag);
        end
    endtask

    // Independent bits: clr clears bit0 while bit1 rises on the same edge.
    task automatic test_multi_bit();
        do_reset();
        bus.btn_raw = 4'b0001;
        step(6);
        bus.btn_raw = 4'b0011;
        step(5);
        bus.clr = 1'b1;
        step(1);
        bus.clr = 1'b0;
        checks++;
        if (bus.btn_flag !== 4'b0010 || bus.btn_level !== 4'b0011 ||
            bus.btn_pulse !== 4'b0010 || bus.btn_overrun !== 4'b0000) begin
            failures++;
            $display("FAIL multi_bit flg=%b lvl=%b pls=%b ovr=%b exp 0010/0011/0010/0000",
                     bus.btn_flag, bus.btn_level, bus.btn_pulse, bus.btn_overrun);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.btn_raw = 4'b0100;
        step(3);                // capture on edge 0, edges 1 and 2 follow
        reset = 1'b1;
        step(1);                // edge 3 sees reset
        reset = 1'b0;
        checks++;
        if (bus.btn_level !== 4'b0000 || bus.btn_pulse !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset lvl=%b pls=%b exp 0000/0000", bus.btn_level, bus.btn_pulse);
        end
        for (int s = 0; s < 5; s++) begin
            step(1);
            checks++;
            if (bus.btn_level !== 4'b0000 || bus.btn_pulse !== 4'b0000) begin
                failures++;
                $display("FAIL mid_reset_hold edge=%0d lvl=%b pls=%b exp 0000/0000",
                         s, bus.btn_level, bus.btn_pulse);
            end
        end
        step(1);
        checks++;
        if (bus.btn_level !== 4'b0100 || bus.btn_pulse !== 4'b0100) begin
            failures++;
            $display("FAIL mid_reset_rise lvl=%b pls=%b exp 0100/0100", bus.btn_level, bus.btn_pulse);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        bus.btn_raw = 4'b0000;
        bus.clr     = 1'b0;
        @(negedge clock);
        test_reset();
        test_clean_press();
        test_clear();
        test_bounce();
        test_collision();
        test_multi_bit();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
